// File: rtl/dma_pkg.sv
// dma_pkg: shared arbiter state encoding, default priority order and rotation helper
package dma_pkg;
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    REQ     = 4'b0010,
    GRANT   = 4'b0100,
    RELEASE = 4'b1000
  } arbState_t;
  localparam logic [7:0] DEFAULT_PRIORITY_ORDER = 8'b11_10_01_00;
  // The channel just serviced drops to the lowest slot; the one after it becomes highest.
  function automatic logic [7:0] rotateOrder(input logic [1:0] c);
    return {c, c + 2'd3, c + 2'd2, c + 2'd1};
  endfunction
endpackage

// File: rtl/dma_priority_encoder.sv
// dma_priority_encoder: picks the first eligible channel scanning priorityOrder from bits [1:0] upward
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [3:0] eligible,
  input  logic [7:0] priorityOrder,
  output logic       anyValid,
  output logic [1:0] winner
);
  // Scanning from lowest to highest priority lets the highest-priority hit be the last write.
  always_comb begin
    anyValid = 1'b0;
    winner = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (eligible[priorityOrder[2*i +: 2]]) begin
        anyValid = 1'b1;
        winner = priorityOrder[2*i +: 2];
      end
  end
endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: 4-channel DMA hold/grant arbiter; rotating priority compiled in with ROTATE_PRIORITY_EN
module dma_priority_arbiter
  import dma_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic [3:0] maskReg,
  input  logic       priorityType,
  input  logic       HLDA,
  input  logic       serviceDone,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       grantValid,
  output logic [1:0] grantChannel,
  output logic [7:0] priorityOrder
);
  arbState_t state, nextState;
  logic [3:0] nextDack;
  logic [1:0] nextChannel;
  logic anyValid;
  logic [1:0] winner;
  logic releaseEdge;

  dma_priority_encoder encoder (
    .eligible(DREQ & ~maskReg),
    .priorityOrder(priorityOrder),
    .anyValid(anyValid),
    .winner(winner)
  );

  always_comb begin
    nextState = state;
    nextDack = DACK;
    nextChannel = grantChannel;
    releaseEdge = 1'b0;
    unique case (state)
      IDLE: nextState = anyValid ? REQ : IDLE;
      REQ:
        if (!anyValid) nextState = IDLE;
        else if (HLDA) begin
          nextState = GRANT;
          nextDack = 4'b0001 << winner;
          nextChannel = winner;
        end
      // Losing HLDA aborts even when serviceDone arrives in the same cycle.
      GRANT:
        if (!HLDA || serviceDone) begin
          nextState = HLDA ? RELEASE : IDLE;
          nextDack = 4'b0000;
          nextChannel = 2'd0;
          releaseEdge = HLDA;
        end
      RELEASE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      DACK <= 4'b0000;
      grantChannel <= 2'd0;
    end else begin
      state <= nextState;
      DACK <= nextDack;
      grantChannel <= nextChannel;
    end

  assign HRQ = (state == REQ) || (state == GRANT);
  assign grantValid = |DACK;

`ifdef ROTATE_PRIORITY_EN
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) priorityOrder <= DEFAULT_PRIORITY_ORDER;
    else if (!priorityType) priorityOrder <= DEFAULT_PRIORITY_ORDER;
    else if (releaseEdge) priorityOrder <= rotateOrder(grantChannel);
`else
  logic unusedRotateInputs;
  assign unusedRotateInputs = priorityType ^ releaseEdge;
  assign priorityOrder = DEFAULT_PRIORITY_ORDER;
`endif
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed scoreboard bench for dma_priority_arbiter
module tb_dma_priority_arbiter;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [3:0] DREQ = 4'b0000;
  logic [3:0] maskReg = 4'b0000;
  logic priorityType = 1'b0;
  logic HLDA = 1'b0;
  logic serviceDone = 1'b0;
  logic HRQ, grantValid;
  logic [3:0] DACK;
  logic [1:0] grantChannel;
  logic [7:0] priorityOrder;
  logic [15:0] obs;
  logic [7:0] ord;
  logic [1:0] w;
  int passed = 0;
  int total = 0;

  typedef struct {
    string tag;
    logic [15:0] exp;
  } item_t;
  item_t sb[$];

  localparam logic [7:0] DEF = 8'b11_10_01_00;

  dma_priority_arbiter dut (
    .CLK(CLK),
    .RESET(RESET),
    .DREQ(DREQ),
    .maskReg(maskReg),
    .priorityType(priorityType),
    .HLDA(HLDA),
    .serviceDone(serviceDone),
    .HRQ(HRQ),
    .DACK(DACK),
    .grantValid(grantValid),
    .grantChannel(grantChannel),
    .priorityOrder(priorityOrder)
  );

  always #5 CLK = ~CLK;

  assign obs = {HRQ, DACK, grantValid, grantChannel, priorityOrder};

  function automatic logic [15:0] mk(input logic hrq, input logic [3:0] dack,
                                     input logic [1:0] ch, input logic [7:0] o);
    return {hrq, dack, |dack, ch, o};
  endfunction

  task automatic push(input string tag, input logic [15:0] e);
    item_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic checkNow();
    item_t it;
    it = sb.pop_front();
    total++;
    assert (obs === it.exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
  endtask

  task automatic expectNext(input string tag, input logic [15:0] e);
    push(tag, e);
    @(posedge CLK);
    #1;
    checkNow();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset dominates active inputs
    DREQ = 4'b1111;
    HLDA = 1'b1;
    expectNext("reset_hold0", mk(0, 4'b0000, 0, DEF));
    expectNext("reset_hold1", mk(0, 4'b0000, 0, DEF));
    DREQ = 4'b0000;
    HLDA = 1'b0;
    RESET = 1'b0;
    expectNext("idle_after_reset", mk(0, 4'b0000, 0, DEF));

    // fixed mode latency and grant stability
    HLDA = 1'b1;
    DREQ = 4'b0110;
    expectNext("lat_hrq", mk(1, 4'b0000, 0, DEF));
    expectNext("lat_dack", mk(1, 4'b0010, 1, DEF));
    DREQ = 4'b1000;
    maskReg = 4'b0010;
    expectNext("grant_stable", mk(1, 4'b0010, 1, DEF));
    maskReg = 4'b0000;
    serviceDone = 1'b1;
    expectNext("release", mk(0, 4'b0000, 0, DEF));
    serviceDone = 1'b0;
    expectNext("release_no_accept", mk(0, 4'b0000, 0, DEF));
    expectNext("rereq", mk(1, 4'b0000, 0, DEF));
    expectNext("regrant_ch3", mk(1, 4'b1000, 3, DEF));
    DREQ = 4'b0000;
    serviceDone = 1'b1;
    expectNext("release2", mk(0, 4'b0000, 0, DEF));
    serviceDone = 1'b0;
    expectNext("idle2", mk(0, 4'b0000, 0, DEF));

    // request withdrawn before HLDA
    HLDA = 1'b0;
    DREQ = 4'b0010;
    expectNext("wd_req", mk(1, 4'b0000, 0, DEF));
    expectNext("wd_wait", mk(1, 4'b0000, 0, DEF));
    DREQ = 4'b0000;
    expectNext("wd_idle", mk(0, 4'b0000, 0, DEF));
    expectNext("wd_still_idle", mk(0, 4'b0000, 0, DEF));

    // hold lost together with serviceDone: abort, no rotation
    priorityType = 1'b1;
    HLDA = 1'b1;
    DREQ = 4'b0100;
    expectNext("ab_req", mk(1, 4'b0000, 0, DEF));
    expectNext("ab_grant", mk(1, 4'b0100, 2, DEF));
    HLDA = 1'b0;
    serviceDone = 1'b1;
    expectNext("ab_abort", mk(0, 4'b0000, 0, DEF));
    serviceDone = 1'b0;
    DREQ = 4'b0000;
    expectNext("ab_idle", mk(0, 4'b0000, 0, DEF));

    // rotating sequence with all channels requesting
    HLDA = 1'b1;
    DREQ = 4'b1111;
    ord = DEF;
    for (int k = 0; k < 5; k++) begin
      w = ord[1:0];
      expectNext("rot_req", mk(1, 4'b0000, 0, ord));
      expectNext("rot_grant", mk(1, 4'b0001 << w, w, ord));
      serviceDone = 1'b1;
`ifdef ROTATE_PRIORITY_EN
      ord = {w, w + 2'd3, w + 2'd2, w + 2'd1};
`endif
      expectNext("rot_release", mk(0, 4'b0000, 0, ord));
      serviceDone = 1'b0;
      expectNext("rot_idle", mk(0, 4'b0000, 0, ord));
    end
    DREQ = 4'b0000;
    priorityType = 1'b0;
    expectNext("fixed_restore", mk(0, 4'b0000, 0, DEF));

    // masked request never raises HRQ
    DREQ = 4'b0001;
    maskReg = 4'b0001;
    for (int k = 0; k < 20; k++) expectNext("masked", mk(0, 4'b0000, 0, DEF));
    DREQ = 4'b0011;
    expectNext("mask_req", mk(1, 4'b0000, 0, DEF));
    expectNext("mask_grant_ch1", mk(1, 4'b0010, 1, DEF));

    // asynchronous reset mid-grant
    HLDA = 1'b0;
    DREQ = 4'b0100;
    maskReg = 4'b0000;
    expectNext("pre_abort", mk(0, 4'b0000, 0, DEF));
    HLDA = 1'b1;
    expectNext("pre_req", mk(1, 4'b0000, 0, DEF));
    expectNext("pre_grant_ch2", mk(1, 4'b0100, 2, DEF));
    #3;
    RESET = 1'b1;
    push("async_reset", mk(0, 4'b0000, 0, DEF));
    #1;
    checkNow();
    RESET = 1'b0;
    DREQ = 4'b0000;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
